// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and lane helper for the dot-product accumulator.
package cnn_pkg;
  localparam int LANES  = 16;
  localparam int DW     = 8;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;
  localparam int WORD_W = 128;
  localparam int PROD_W = 2 * DW;
  localparam int SUM_W  = 2 * DW + 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  function automatic logic signed [DW-1:0] lane(input logic [WORD_W-1:0] word, input int idx);
    return word[idx*DW +: DW];
  endfunction
endpackage

// File: rtl/dot_accum_engine_if.sv
// Beat input, config and result handshake bundle for dot_accum_engine.
interface dot_accum_engine_if;
  import cnn_pkg::*;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] img_data;
  logic [WORD_W-1:0] wgt_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  modport master (output cfg_len, in_valid, img_data, wgt_data, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  cfg_len, in_valid, img_data, wgt_data, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/dot_accum_engine_lane_mult_tree.sv
// Two-stage lane multiply + adder tree: S1 registers products, S2 registers their sum.
module lane_mult_tree
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       img,
  input  logic [WORD_W-1:0]       wgt,
  output logic                    s1_valid,
  output logic                    out_valid,
  output logic signed [SUM_W-1:0] sum
);
  localparam int STAGES = 2;

  logic [STAGES:1]          vld_pipe;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  tree_sum;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[1], in_valid};
  end

  // Data stages carry no reset; the valid pipe qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      prod_q[i] <= PROD_W'(lane(img, i)) * PROD_W'(lane(wgt, i));
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++)
      tree_sum = tree_sum + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk) sum <= tree_sum;

  assign s1_valid  = vld_pipe[1];
  assign out_valid = vld_pipe[2];
endmodule

// File: rtl/dot_accum_engine.sv
// Accumulates cfg_len beats of 16-lane dot products into one result with a single-entry output slot.
module dot_accum_engine
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dot_accum_engine_if.slave bus
);
  state_t                  state;
  logic [LEN_W:0]          len_q, count, len_eff;
  logic [1:0]              dcnt;
  logic signed [ACC_W-1:0] acc;
  logic                    accept, slot_free, s1_valid, s2_valid;
  logic signed [SUM_W-1:0] s2_sum;

  assign accept    = bus.in_valid && bus.in_ready;
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign len_eff   = (bus.cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.cfg_len};
  assign bus.busy  = (state != IDLE) || s1_valid || s2_valid;

  lane_mult_tree u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .img       (bus.img_data),
    .wgt       (bus.wgt_data),
    .s1_valid  (s1_valid),
    .out_valid (s2_valid),
    .sum       (s2_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      len_q         <= '0;
      count         <= '0;
      dcnt          <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (s2_valid) acc <= acc + ACC_W'(s2_sum);
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            len_q <= len_eff;
            count <= (LEN_W+1)'(1);
            dcnt  <= '0;
            if (len_eff == (LEN_W+1)'(1)) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            count <= count + 1'b1;
            if (count + 1'b1 == len_q) begin
              state        <= DRAIN;
              bus.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          bus.in_ready <= 1'b0;
          // Two flush cycles let the last beat reach acc before it is handed off.
          if (dcnt != 2'd2) begin
            dcnt <= dcnt + 1'b1;
          end else if (slot_free) begin
            bus.out_data  <= acc;
            bus.out_valid <= 1'b1;
            acc           <= '0;
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_accum_engine.sv
// Directed bench: scoreboard queue of expected results, popped on each output handshake.
module tb_dot_accum_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_accum_engine_if bus ();
  dot_accum_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;
  int n_out  = 0;
  logic [31:0] last_out = '0;
  logic [31:0] q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rep(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic int dot(input logic [127:0] a, input logic [127:0] b);
    int s = 0;
    for (int i = 0; i < 16; i++)
      s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
    return s;
  endfunction

  // Presents one beat and returns #1 after the edge that accepted it; in_valid stays high.
  task automatic beat(input logic [127:0] a, input logic [127:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.img_data = a;
    bus.wgt_data = b;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("beat_wait_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.out_valid || q.size() != 0) && n < 400) begin tick(); n++; end
    if (n >= 400) chk("idle_wait_timeout", 32'(n), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (prev_hold) chk("hold_stable", bus.out_data, prev_data);
      if (bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 32'(q.size()), 32'd1);
        else chk("result", bus.out_data, q.pop_front());
        last_out = bus.out_data;
        n_out++;
      end
    end
    prev_hold = !rst && bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
  end

  initial begin
    int lat, n0, exp5, rose;
    logic [127:0] a5 [3];
    logic [127:0] b5 [3];
    logic [127:0] ea, eb;
    bus.cfg_len = 8'd1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.img_data = '0; bus.wgt_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: len=1, 1*2 per lane
    q.push_back(32'd32);
    beat(rep(8'd1), rep(8'd2));
    bus.in_valid = 1'b0;
    chk("t1_drain_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 10) begin tick(); lat++; end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_data", bus.out_data, 32'd32);
    wait_idle();

    // 2: len=4, -1*3 per lane; cfg_len change mid-group ignored
    n0 = n_out;
    bus.cfg_len = 8'd4;
    q.push_back(32'hFFFFFF40);
    beat(rep(8'hFF), rep(8'd3));
    bus.cfg_len = 8'd7;
    repeat (3) beat(rep(8'hFF), rep(8'd3));
    bus.in_valid = 1'b0;
    wait_idle();
    chk("t2_count", 32'(n_out - n0), 32'd1);
    chk("t2_data", last_out, 32'hFFFFFF40);

    // 3: len=0 means 256, -128*-128 per lane
    bus.cfg_len = 8'd0;
    q.push_back(32'h04000000);
    repeat (255) beat(rep(8'h80), rep(8'h80));
    chk("t3_still_accum", 32'(bus.in_ready), 32'd1);
    beat(rep(8'h80), rep(8'h80));
    bus.in_valid = 1'b0;
    wait_idle();
    chk("t3_data", last_out, 32'h04000000);

    // 4: two len=2 groups with output back-pressured
    bus.cfg_len = 8'd2;
    bus.out_ready = 1'b0;
    ea = rep(8'd7); eb = rep(8'hFB);
    q.push_back(32'(2 * dot(ea, rep(8'd9))));
    q.push_back(32'(2 * dot(eb, rep(8'd11))));
    repeat (2) beat(ea, rep(8'd9));
    bus.in_valid = 1'b0;
    repeat (2) beat(eb, rep(8'd11));
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("t4_drain_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    chk("t4_first_held", bus.out_data, 32'(2 * dot(ea, rep(8'd9))));
    repeat (8) tick();
    bus.out_ready = 1'b1;
    tick();
    chk("t4_second_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_second_data", bus.out_data, 32'(2 * dot(eb, rep(8'd11))));
    wait_idle();
    chk("t4_queue_empty", 32'(q.size()), 32'd0);

    // 5: len=3 with bubbles; data on bubble cycles must not count
    bus.cfg_len = 8'd3;
    exp5 = 0;
    for (int k = 0; k < 3; k++) begin
      a5[k] = {$urandom, $urandom, $urandom, $urandom};
      b5[k] = {$urandom, $urandom, $urandom, $urandom};
      exp5 += dot(a5[k], b5[k]);
    end
    q.push_back(32'(exp5));
    for (int k = 0; k < 3; k++) begin
      beat(a5[k], b5[k]);
      bus.in_valid = 1'b0;
      bus.img_data = rep(8'h7F);
      bus.wgt_data = rep(8'h7F);
      if (k < 2) begin
        tick();
        chk("t5_bubble_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    wait_idle();
    chk("t5_data", last_out, 32'(exp5));

    // 6: reset after 2 of 4 beats discards the group
    n0 = n_out;
    bus.cfg_len = 8'd4;
    repeat (2) beat(rep(8'd5), rep(8'd5));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    rose = 0;
    repeat (10) begin tick(); if (bus.out_valid) rose = 1; end
    chk("t6_no_output", 32'(rose), 32'd0);
    bus.cfg_len = 8'd1;
    q.push_back(32'(dot(rep(8'd3), rep(8'hFE))));
    beat(rep(8'd3), rep(8'hFE));
    bus.in_valid = 1'b0;
    wait_idle();
    chk("t6_clean_data", last_out, 32'hFFFFFFA0);
    chk("t6_count", 32'(n_out - n0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
